// File: rtl/add_operand_sequencer_pkg.sv
// rtl/add_operand_sequencer_pkg.sv - shared state encoding and control-byte layout
package add_operand_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  localparam int CTRL_CIN_BIT = 0;

  // Byte counter must reach 2*nbytes (the control byte index).
  function automatic int byte_cnt_width(input int nbytes);
    return $clog2(2 * nbytes + 1);
  endfunction

endpackage

// File: rtl/add_operand_sequencer_collector.sv
// rtl/add_operand_sequencer_collector.sv - byte-lane decoder and A/B/cin operand registers
module add_operand_sequencer_collector
  import add_operand_sequencer_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int DATA_W = 8 * NBYTES,
  parameter int BCNT_W = byte_cnt_width(NBYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              accept,
  input  logic              flush,
  output logic [BCNT_W-1:0] byte_cnt,
  output logic              ctrl_byte,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_cin
);

  localparam logic [BCNT_W-1:0] CTRL_IDX = BCNT_W'(2 * NBYTES);

  assign ctrl_byte = (byte_cnt == CTRL_IDX);

  // Byte counter plus lane writes; operands are only overwritten, never cleared between transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
    end else if (flush) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= ctrl_byte ? '0 : byte_cnt + BCNT_W'(1);
      for (int k = 0; k < NBYTES; k++) begin
        if (byte_cnt == BCNT_W'(k))
          op_a[8*k +: 8] <= in_data;
        if (byte_cnt == BCNT_W'(NBYTES + k))
          op_b[8*k +: 8] <= in_data;
      end
      if (ctrl_byte)
        op_cin <= in_data[CTRL_CIN_BIT];
    end
  end

endmodule

// File: rtl/add_operand_sequencer.sv
// rtl/add_operand_sequencer.sv - byte-stream front end that loads, launches and returns one wide add
module add_operand_sequencer
  import add_operand_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_cin,
  input  logic [DATA_W-1:0] add_sum,
  input  logic              add_cout,
  input  logic              add_ovf,
  output logic [DATA_W-1:0] res_sum,
  output logic              res_cout,
  output logic              res_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BCNT_W = byte_cnt_width(NBYTES);

  state_t             state, state_nxt;
  logic [BCNT_W-1:0]  byte_cnt;
  logic               ctrl_byte;
  logic               accept;
  logic               handoff;

  assign in_ready = (state == ST_LOAD);
  // flush outranks both the byte accept and the result hand-off.
  assign accept   = in_valid & in_ready & ~flush;
  assign handoff  = (state == ST_RESULT) & res_valid & res_ready & ~flush;
  assign busy     = (state != ST_LOAD) || (byte_cnt != '0);

  add_operand_sequencer_collector #(
    .NBYTES (NBYTES),
    .DATA_W (DATA_W),
    .BCNT_W (BCNT_W)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .accept    (accept),
    .flush     (flush),
    .byte_cnt  (byte_cnt),
    .ctrl_byte (ctrl_byte),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_LOAD;
    else
      state <= state_nxt;
  end

  // Next-state: load bytes, one settle cycle for the adder, then hold until consumed.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD:   if (accept && ctrl_byte) state_nxt = ST_EXEC;
        ST_EXEC:   state_nxt = ST_RESULT;
        ST_RESULT: if (handoff) state_nxt = ST_LOAD;
        default:   state_nxt = ST_LOAD;
      endcase
    end
  end

  // Result capture at the end of EXEC, hand-off bookkeeping in RESULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
      res_valid <= 1'b0;
      ops_done  <= '0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (state == ST_EXEC) begin
      res_sum   <= add_sum;
      res_cout  <= add_cout;
      res_ovf   <= add_ovf;
      res_valid <= 1'b1;
    end else if (handoff) begin
      res_valid <= 1'b0;
      ops_done  <= ops_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_add_operand_sequencer.sv
// tb/tb_add_operand_sequencer.sv - directed self-checking bench for add_operand_sequencer
module tb_add_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] op_a, op_b;
  logic        op_cin;
  logic [31:0] add_sum;
  logic        add_cout, add_ovf;
  logic [31:0] res_sum;
  logic        res_cout, res_ovf, res_valid;
  logic        res_ready;
  logic        busy;
  logic [15:0] ops_done;

  logic        in_ready_s, op_cin_s, res_cout_s, res_ovf_s, res_valid_s, busy_s;
  logic [31:0] op_a_s, op_b_s, res_sum_s;
  logic [2:0]  ops_done_s;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Environment model of the external 32-bit adder.
  logic [32:0] full_sum;
  assign full_sum = {1'b0, op_a} + {1'b0, op_b} + {32'd0, op_cin};
  assign add_sum  = full_sum[31:0];
  assign add_cout = full_sum[32];
  assign add_ovf  = (op_a[31] == op_b[31]) && (full_sum[31] != op_a[31]);

  add_operand_sequencer #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .ops_done(ops_done)
  );

  // Narrow-counter twin sharing the same stimulus, used to reach the counter wrap quickly.
  add_operand_sequencer #(.DATA_W(32), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
    .flush(flush), .op_a(op_a_s), .op_b(op_b_s), .op_cin(op_cin_s),
    .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf),
    .res_sum(res_sum_s), .res_cout(res_cout_s), .res_ovf(res_ovf_s),
    .res_valid(res_valid_s), .res_ready(res_ready), .busy(busy_s), .ops_done(ops_done_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctrl);
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    for (int k = 0; k < 4; k++) send_byte(b[8*k +: 8]);
    send_byte(ctrl);
  endtask

  // Full transaction with res_ready held high; checks latency, result and counter.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctrl,
                         input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                         input logic [15:0] exp_ops);
    res_ready = 1'b1;
    send_op(a, b, ctrl);
    @(negedge clk);
    check("exec_res_valid", {31'd0, res_valid}, 32'd0);
    check("exec_in_ready", {31'd0, in_ready}, 32'd0);
    check("exec_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("res_valid", {31'd0, res_valid}, 32'd1);
    check("res_sum", res_sum, exp_sum);
    check("res_cout", {31'd0, res_cout}, {31'd0, exp_cout});
    check("res_ovf", {31'd0, res_ovf}, {31'd0, exp_ovf});
    @(negedge clk);
    check("post_res_valid", {31'd0, res_valid}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
    check("ops_done", {16'd0, ops_done}, {16'd0, exp_ops});
    check("ops_done_small", {29'd0, ops_done_s}, {29'd0, exp_ops[2:0]});
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; flush = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_ops_done", {16'd0, ops_done}, 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_res_sum", res_sum, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Signed overflow into the sign bit
    run_txn(32'h7FFFFFFF, 32'h00000001, 8'h00, 32'h80000000, 1'b0, 1'b1, 16'd1);
    // Unsigned carry out, no signed overflow
    run_txn(32'hFFFFFFFF, 32'h00000001, 8'h00, 32'h00000000, 1'b1, 1'b0, 16'd2);
    // Carry-in only; upper control bits ignored
    run_txn(32'h00000000, 32'h00000000, 8'hFF, 32'h00000001, 1'b0, 1'b0, 16'd3);

    // Backpressure in RESULT
    res_ready = 1'b0;
    send_op(32'h00000005, 32'h00000003, 8'h01);
    repeat (2) @(negedge clk);
    check("bp_res_valid", {31'd0, res_valid}, 32'd1);
    check("bp_res_sum", res_sum, 32'h00000009);
    in_data = 8'hAA; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, res_valid}, 32'd1);
      check("bp_hold_sum", res_sum, 32'h00000009);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check("bp_op_a_kept", op_a, 32'h00000005);
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, res_valid}, 32'd0);
    check("bp_ops_done", {16'd0, ops_done}, 32'd4);

    // Flush after three bytes; the byte in the flush cycle is dropped
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    check("partial_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_op_a", op_a, 32'h00CCBBAA);
    run_txn(32'h12345678, 32'h11111111, 8'h00, 32'h23456789, 1'b0, 1'b0, 16'd5);

    // Asynchronous reset while holding a result
    res_ready = 1'b0;
    send_op(32'h00000001, 32'h00000002, 8'h00);
    repeat (2) @(negedge clk);
    check("pre_rst_valid", {31'd0, res_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_res_valid", {31'd0, res_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_ops_done", {16'd0, ops_done}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_op_a", op_a, 32'd0);
    check("arst_res_sum", res_sum, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Flush beats res_ready in RESULT
    send_op(32'h00000010, 32'h00000020, 8'h00);
    repeat (2) @(negedge clk);
    check("pre_flush_sum", res_sum, 32'h00000030);
    flush = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; res_ready = 1'b0;
    check("flush_res_valid", {31'd0, res_valid}, 32'd0);
    check("flush_ops_done", {16'd0, ops_done}, 32'd0);
    check("flush_res_kept", res_sum, 32'h00000030);
    check("flush_rs_in_ready", {31'd0, in_ready}, 32'd1);

    // Counter wrap, observed on the 3-bit twin at 7 -> 0
    for (int i = 1; i <= 8; i++)
      run_txn(32'(i), 32'h00000100, 8'h00, 32'(i) + 32'h100, 1'b0, 1'b0, 16'(i));
    check("wrap_small_zero", {29'd0, ops_done_s}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_operand_sequencer.md
Name: add_operand_sequencer

Overview:
Upstream front-end for the team's 32-bit combinational adder. Takes a byte-wide valid/ready stream and assembles operand A, operand B and carry-in. It drives these as stable registered operands into the adder, then samples the adder's sum/cout/overflow one cycle later. The registered result is returned through a valid/ready result port, so a narrow bus or serial host can use the wide adder without combinational paths crossing the boundary.

Parameters:
DATA_W, 32, operand/sum width in bits; must be a multiple of 8
NBYTES, DATA_W/8, bytes per operand (derived localparam, not overridable)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  8  operand stream byte
in_valid  in  1  in_data valid
in_ready  out  1  block accepts a byte this cycle
flush  in  1  synchronous abort of current transaction
op_a  out  DATA_W  registered operand A to adder
op_b  out  DATA_W  registered operand B to adder
op_cin  out  1  registered carry-in to adder
add_sum  in  DATA_W  adder sum (combinational from op_*)
add_cout  in  1  adder carry-out
add_ovf  in  1  adder signed overflow
res_sum  out  DATA_W  registered result
res_cout  out  1  registered carry-out
res_ovf  out  1  registered overflow
res_valid  out  1  result available
res_ready  in  1  consumer takes result
busy  out  1  high whenever state is not LOAD or byte counter is nonzero
ops_done  out  CNT_W  count of results handed off; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1): state=LOAD, byte_cnt=0, op_a/op_b/op_cin=0, res_sum=0, res_cout=0, res_ovf=0, res_valid=0, ops_done=0. in_ready=1 immediately after rst deasserts. busy=0.
- Byte accept = in_valid & in_ready. in_ready = (state==LOAD).
- LOAD, stream order is little-endian:
  - bytes 0..NBYTES-1 fill op_a[8k+7:8k].
  - bytes NBYTES..2*NBYTES-1 fill op_b.
  - byte 2*NBYTES is control: bit0 -> op_cin; bits 7:1 ignored.
  - byte_cnt increments per accept.
  - On the control-byte accept, byte_cnt returns to 0 and the state moves to EXEC.
- EXEC (exactly 1 cycle): in_ready=0. op_* are stable, so the adder output has settled. At the end of the cycle, capture add_sum/add_cout/add_ovf into res_* and set res_valid=1. State moves to RESULT.
- RESULT: res_valid=1; res_* and op_* held constant.
  - On res_valid & res_ready: res_valid=0, ops_done+1, state moves to LOAD. in_ready=1 next cycle.
  - No bypass: res_ready high on the EXEC cycle has no effect.
- Latency: control byte accepted at edge T, res_valid high after edge T+1, i.e. 2 cycles. Minimum transaction period is 2*NBYTES+3 cycles.
- op_a/op_b keep their last values between transactions and are overwritten bytewise. There is no clearing on LOAD entry.
- res_* hold the last result after hand-off until the next EXEC.
- flush (state-independent, highest priority over byte accept and res_ready):
  - next state=LOAD, byte_cnt=0, res_valid=0.
  - ops_done is not incremented, even if res_ready is high in the same cycle.
  - op_* and res_* data keep their values; a byte presented in the flush cycle is not accepted.
- Backpressure: while res_ready=0 in RESULT, the block stalls indefinitely with in_ready=0.
- ops_done wraps from 2^CNT_W-1 to 0.
- Reset mid-transaction discards everything; no partial result is ever presented.

Decomposition:
- Shared package: state encoding (LOAD=2'd0, EXEC=2'd1, RESULT=2'd2) and the control-byte bit index for cin (CTRL_CIN_BIT=0).
- One natural sub-module: byte_shift_collector, the byte-lane write-enable decoder plus A/B/cin registers indexed by byte_cnt.
- FSM, result registers and counter stay in the top module.
- The adder is instantiated by the parent next to this block, not inside it.

Test Plan:
- Stream FF FF FF 7F 01 00 00 00 00, res_ready=1 -> res_sum=0x80000000, res_cout=0, res_ovf=1, res_valid 2 cycles after last accept, ops_done=1.
- Stream FF FF FF FF 01 00 00 00 00 -> res_sum=0x00000000, res_cout=1, res_ovf=0; then all-zero operands with control byte 0x01 -> res_sum=0x00000001, cout=0, ovf=0.
- Complete a transaction, then hold res_ready=0 for 5 cycles -> res_valid stays 1, res_* constant, in_ready=0, in_valid bytes not accepted; res_ready=1 -> in_ready=1 next cycle.
- Send 3 bytes, pulse flush with in_valid=1 -> byte_cnt=0, busy=0, that byte not taken; next 9 bytes (A=0x12345678, B=0x11111111, cin 0) -> res_sum=0x23456789.
- Assert rst while in RESULT -> res_valid=0, in_ready=1, ops_done=0 immediately and asynchronously; flush together with res_ready in RESULT -> ops_done unchanged.
- Preload ops_done at 0xFFFF (force or 65535 transactions) and complete one more -> ops_done=0x0000.
